// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave transmitter control path:
//   - state_t            : control FSM state encoding
//   - SDA_* constants    : encodings of the sda_mode output
//   - SLAVE_ADDR_DEFAULT : default 7-bit bus address of this slave
// No ports (package).
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_CHECK = 4'd2,
        ACK_WAIT   = 4'd3,
        ACK        = 4'd4,
        NACK_WAIT  = 4'd5,
        NACK       = 4'd6,
        LOAD       = 4'd7,
        TX         = 4'd8,
        MACK_WAIT  = 4'd9,
        MACK_CHECK = 4'd10,
        POP        = 4'd11,
        POP_WAIT   = 4'd12
    } state_t;

    // sda_mode: what the SDA output stage should do this cycle
    localparam logic [1:0] SDA_IDLE = 2'b00;  // release, bus pulled high
    localparam logic [1:0] SDA_ACK  = 2'b01;  // drive low in ACK slot
    localparam logic [1:0] SDA_NACK = 2'b10;  // hold high in ACK slot
    localparam logic [1:0] SDA_TX   = 2'b11;  // drive TX shift register bit

    localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'b1111000;

endpackage

// File: rtl/i2c_slave_controller_if.sv
// -----------------------------------------------------------------------------
// i2c_slave_controller_if
// Groups the handshake signals between the control FSM and its neighbours
// (bit timer, start/stop detector, RX/TX shift registers, TX FIFO).
//   slave  modport : view of the control FSM (consumes events, drives enables)
//   master modport : view of the surrounding datapath / testbench
// Signals:
//   start_found, stop_found   : bus condition pulses
//   byte_received, ack_prep,
//   check_ack, ack_done       : bit-timer events
//   sda_in                    : synchronized SDA
//   rx_data[7:0]              : RX shift register contents, bit0 = R/W
//   tx_fifo_empty             : TX FIFO status
//   rx_enable, tx_enable      : shift register enables
//   load_data, read_enable    : TX load / FIFO pop pulses
//   sda_mode[1:0]             : SDA driver mode
// -----------------------------------------------------------------------------
interface i2c_slave_controller_if;

    logic       start_found;
    logic       stop_found;
    logic       byte_received;
    logic       ack_prep;
    logic       check_ack;
    logic       ack_done;
    logic       sda_in;
    logic [7:0] rx_data;
    logic       tx_fifo_empty;
    logic       rx_enable;
    logic       tx_enable;
    logic       load_data;
    logic       read_enable;
    logic [1:0] sda_mode;

    modport slave (
        input  start_found, stop_found, byte_received, ack_prep,
               check_ack, ack_done, sda_in, rx_data, tx_fifo_empty,
        output rx_enable, tx_enable, load_data, read_enable, sda_mode
    );

    modport master (
        output start_found, stop_found, byte_received, ack_prep,
               check_ack, ack_done, sda_in, rx_data, tx_fifo_empty,
        input  rx_enable, tx_enable, load_data, read_enable, sda_mode
    );

endinterface

// File: rtl/i2c_slave_controller.sv
// -----------------------------------------------------------------------------
// i2c_slave_controller
// Control FSM of the I2C slave transmitter. Matches the received address,
// sequences ACK/NACK driving, enables the RX/TX shift registers, loads the
// TX shift register and pops the TX FIFO after each master ACK.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : i2c_slave_controller_if.slave (events in, enables / sda_mode out)
// Parameter:
//   SLAVE_ADDR : 7-bit bus address this slave answers to
// Moore machine: every output is decoded from the state register only, so
// outputs react one cycle after the event that moved the state.
// -----------------------------------------------------------------------------
module i2c_slave_controller
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    i2c_slave_controller_if.slave         bus
);

    state_t state_q, state_d;
    logic   sda_in_q, sda_in_d;
    logic   addr_match;

    // Only a read addressed to us with data available is acknowledged;
    // anything else is NACKed so the master never clocks out stale data.
    assign addr_match = (bus.rx_data[7:1] == SLAVE_ADDR) && bus.rx_data[0] &&
                        !bus.tx_fifo_empty;

    // SDA is captured every cycle; on entry to MACK_CHECK the register holds
    // the value seen in the cycle check_ack was first observed.
    assign sda_in_d = bus.sda_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sda_in_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sda_in_q <= sda_in_d;
        end
    end

    // Next-state logic. Stop and (repeated) start override every state,
    // with stop taking priority when both arrive together.
    always_comb begin
        state_d = state_q;
        if (bus.stop_found) begin
            state_d = IDLE;
        end else if (bus.start_found) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                IDLE:       state_d = IDLE;
                ADDR:       if (bus.byte_received) state_d = ADDR_CHECK;
                ADDR_CHECK: state_d = addr_match ? ACK_WAIT : NACK_WAIT;
                ACK_WAIT:   if (bus.ack_prep) state_d = ACK;
                ACK:        if (bus.ack_done) state_d = LOAD;
                NACK_WAIT:  if (bus.ack_prep) state_d = NACK;
                NACK:       if (bus.ack_done) state_d = IDLE;
                LOAD:       state_d = TX;
                TX:         if (bus.ack_prep) state_d = MACK_WAIT;
                MACK_WAIT: begin
                    // ack_done without a check_ack window means the ACK
                    // slot was missed; treat it as a NACK.
                    if (bus.check_ack)     state_d = MACK_CHECK;
                    else if (bus.ack_done) state_d = IDLE;
                end
                MACK_CHECK: state_d = sda_in_q ? IDLE : POP;
                POP:        state_d = POP_WAIT;
                POP_WAIT: begin
                    if (bus.ack_done) state_d = bus.tx_fifo_empty ? IDLE : LOAD;
                end
                default:    state_d = IDLE;
            endcase
        end
    end

    // Output decode from the registered state. load_data is additionally
    // masked by the FIFO status so an empty FIFO is never loaded.
    always_comb begin
        bus.rx_enable   = 1'b0;
        bus.tx_enable   = 1'b0;
        bus.load_data   = 1'b0;
        bus.read_enable = 1'b0;
        bus.sda_mode    = SDA_IDLE;
        case (state_q)
            ADDR:  bus.rx_enable   = 1'b1;
            ACK:   bus.sda_mode    = SDA_ACK;
            NACK:  bus.sda_mode    = SDA_NACK;
            LOAD:  bus.load_data   = !bus.tx_fifo_empty;
            TX: begin
                bus.sda_mode  = SDA_TX;
                bus.tx_enable = 1'b1;
            end
            POP:   bus.read_enable = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_controller
// Directed testbench for the I2C slave control FSM. Outputs are observed
// as the packed vector {rx_enable, tx_enable, load_data, read_enable,
// sda_mode} one time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_i2c_slave_controller;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   load_cnt;
    int   read_cnt;
    logic [5:0] outs;

    i2c_slave_controller_if bus ();

    i2c_slave_controller #(.SLAVE_ADDR(7'b1111000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign outs = {bus.rx_enable, bus.tx_enable, bus.load_data,
                   bus.read_enable, bus.sda_mode};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge
    initial begin
        load_cnt = 0;
        read_cnt = 0;
    end
    always @(negedge clk) begin
        if (bus.load_data === 1'b1)   load_cnt++;
        if (bus.read_enable === 1'b1) read_cnt++;
    end

    // Advance one clock; outputs are stable right after this returns
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_found = 1'b1; step(); bus.start_found = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_found = 1'b1; step(); bus.stop_found = 1'b0;
    endtask

    task automatic pulse_ack_prep();
        bus.ack_prep = 1'b1; step(); bus.ack_prep = 1'b0;
    endtask

    task automatic pulse_ack_done();
        bus.ack_done = 1'b1; step(); bus.ack_done = 1'b0;
    endtask

    // Addresses the slave for a read (0xF1) and walks into the TX state
    task automatic go_to_tx();
        bus.rx_data = 8'hF1;
        bus.tx_fifo_empty = 1'b0;
        pulse_start();
        bus.byte_received = 1'b1; step(); bus.byte_received = 1'b0;
        step();
        pulse_ack_prep();
        pulse_ack_done();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL reset_idle: got=%b exp=%b", outs, 6'b000000); end
        go_to_tx();
        checks++; if (outs !== 6'b010011) begin errors++; $display("[TB] FAIL reset_pre_tx: got=%b exp=%b", outs, 6'b010011); end
        rst = 1'b1;
        step();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL reset_mid_tx: got=%b exp=%b", outs, 6'b000000); end
        bus.start_found = 1'b1; step(); bus.start_found = 1'b0;
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL reset_beats_start: got=%b exp=%b", outs, 6'b000000); end
        rst = 1'b0;
        step();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL reset_release_idle: got=%b exp=%b", outs, 6'b000000); end
    endtask

    task automatic test_address_match();
        bus.rx_data = 8'hF1;
        bus.tx_fifo_empty = 1'b0;
        pulse_start();
        checks++; if (outs !== 6'b100000) begin errors++; $display("[TB] FAIL match_addr_rx: got=%b exp=%b", outs, 6'b100000); end
        bus.byte_received = 1'b1; step(); bus.byte_received = 1'b0;
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL match_addr_check: got=%b exp=%b", outs, 6'b000000); end
        step();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL match_ack_wait: got=%b exp=%b", outs, 6'b000000); end
        pulse_ack_prep();
        checks++; if (outs !== 6'b000001) begin errors++; $display("[TB] FAIL match_ack: got=%b exp=%b", outs, 6'b000001); end
        step();
        checks++; if (outs !== 6'b000001) begin errors++; $display("[TB] FAIL match_ack_hold: got=%b exp=%b", outs, 6'b000001); end
        pulse_ack_done();
        checks++; if (outs !== 6'b001000) begin errors++; $display("[TB] FAIL match_load: got=%b exp=%b", outs, 6'b001000); end
        step();
        checks++; if (outs !== 6'b010011) begin errors++; $display("[TB] FAIL match_tx: got=%b exp=%b", outs, 6'b010011); end
        step();
        checks++; if (outs !== 6'b010011) begin errors++; $display("[TB] FAIL match_tx_hold: got=%b exp=%b", outs, 6'b010011); end
        pulse_stop();
    endtask

    task automatic test_address_mismatch();
        logic [7:0] addr_tab [3];
        logic       empty_tab [3];
        addr_tab[0] = 8'hA1; empty_tab[0] = 1'b0;  // wrong address
        addr_tab[1] = 8'hF0; empty_tab[1] = 1'b0;  // write request
        addr_tab[2] = 8'hF1; empty_tab[2] = 1'b1;  // nothing to send
        for (int v = 0; v < 3; v++) begin
            bus.rx_data = addr_tab[v];
            bus.tx_fifo_empty = empty_tab[v];
            pulse_start();
            bus.byte_received = 1'b1; step(); bus.byte_received = 1'b0;
            step();
            checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL nack_wait_%0d: got=%b exp=%b", v, outs, 6'b000000); end
            pulse_ack_prep();
            checks++; if (outs !== 6'b000010) begin errors++; $display("[TB] FAIL nack_slot_%0d: got=%b exp=%b", v, outs, 6'b000010); end
            pulse_ack_done();
            checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL nack_idle_%0d: got=%b exp=%b", v, outs, 6'b000000); end
            bus.byte_received = 1'b1; step(); bus.byte_received = 1'b0;
            pulse_ack_prep();
            checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL nack_deaf_%0d: got=%b exp=%b", v, outs, 6'b000000); end
        end
        bus.tx_fifo_empty = 1'b0;
    endtask

    task automatic test_multi_byte();
        int load_start;
        int read_start;
        load_start = load_cnt;
        read_start = read_cnt;
        go_to_tx();
        for (int b = 0; b < 3; b++) begin
            pulse_ack_prep();
            checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL multi_mack_wait_%0d: got=%b exp=%b", b, outs, 6'b000000); end
            // Master answer is only valid during check_ack; flip it afterwards
            bus.check_ack = 1'b1;
            bus.sda_in = (b == 2);
            step();
            bus.check_ack = 1'b0;
            bus.sda_in = (b != 2);
            step();
            if (b < 2) begin
                checks++; if (outs !== 6'b000100) begin errors++; $display("[TB] FAIL multi_pop_%0d: got=%b exp=%b", b, outs, 6'b000100); end
                step();
                checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL multi_pop_wait_%0d: got=%b exp=%b", b, outs, 6'b000000); end
                pulse_ack_done();
                checks++; if (outs !== 6'b001000) begin errors++; $display("[TB] FAIL multi_load_%0d: got=%b exp=%b", b, outs, 6'b001000); end
                step();
                checks++; if (outs !== 6'b010011) begin errors++; $display("[TB] FAIL multi_tx_%0d: got=%b exp=%b", b, outs, 6'b010011); end
            end else begin
                checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL multi_nack_idle: got=%b exp=%b", outs, 6'b000000); end
            end
        end
        bus.sda_in = 1'b1;
        step();
        checks++; if ((load_cnt - load_start) !== 3) begin errors++; $display("[TB] FAIL multi_load_count: got=%0d exp=%0d", load_cnt - load_start, 3); end
        checks++; if ((read_cnt - read_start) !== 2) begin errors++; $display("[TB] FAIL multi_read_count: got=%0d exp=%0d", read_cnt - read_start, 2); end
    endtask

    task automatic test_overrides();
        // stop during TX
        go_to_tx();
        pulse_stop();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL ovr_stop_tx: got=%b exp=%b", outs, 6'b000000); end
        // repeated start during POP_WAIT
        go_to_tx();
        pulse_ack_prep();
        bus.check_ack = 1'b1; bus.sda_in = 1'b0; step();
        bus.check_ack = 1'b0; bus.sda_in = 1'b1;
        step(); step();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL ovr_pop_wait: got=%b exp=%b", outs, 6'b000000); end
        pulse_start();
        checks++; if (outs !== 6'b100000) begin errors++; $display("[TB] FAIL ovr_restart: got=%b exp=%b", outs, 6'b100000); end
        // stop and start together: stop wins
        bus.stop_found = 1'b1; bus.start_found = 1'b1; step();
        bus.stop_found = 1'b0; bus.start_found = 1'b0;
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL ovr_stop_wins: got=%b exp=%b", outs, 6'b000000); end
        step();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL ovr_stays_idle: got=%b exp=%b", outs, 6'b000000); end
    endtask

    task automatic test_missed_ack_slot();
        go_to_tx();
        pulse_ack_prep();
        pulse_ack_done();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL missed_slot_idle: got=%b exp=%b", outs, 6'b000000); end
        // A late check_ack with ACK must not lead to a FIFO pop from IDLE
        bus.check_ack = 1'b1; bus.sda_in = 1'b0; step();
        bus.check_ack = 1'b0;
        step();
        checks++; if (outs !== 6'b000000) begin errors++; $display("[TB] FAIL missed_slot_no_pop: got=%b exp=%b", outs, 6'b000000); end
        bus.sda_in = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.start_found   = 1'b0;
        bus.stop_found    = 1'b0;
        bus.byte_received = 1'b0;
        bus.ack_prep      = 1'b0;
        bus.check_ack     = 1'b0;
        bus.ack_done      = 1'b0;
        bus.sda_in        = 1'b1;
        bus.rx_data       = 8'h00;
        bus.tx_fifo_empty = 1'b0;

        test_reset();
        test_address_match();
        test_address_mismatch();
        test_multi_byte();
        test_overrides();
        test_missed_ack_slot();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_controller.md
Name: i2c_slave_controller

Overview:
Control FSM of the I2C slave transmitter. It sits directly downstream of the bit-timer block and consumes byte_received, ack_prep, check_ack and ack_done, plus start/stop detection and the received address byte. It matches the address and sequences ACK/NACK driving. It also enables the RX/TX shift registers and pops the TX FIFO after each master ACK.

Parameters:
SLAVE_ADDR, 7'b1111000, 7-bit bus address this slave answers to.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_found  in  1  start or repeated start detected, 1-cycle pulse
stop_found  in  1  stop detected, 1-cycle pulse
byte_received  in  1  timer: 8 bits clocked (level while count==8)
ack_prep  in  1  timer: falling SCL edge after 8th bit, pulse
check_ack  in  1  timer: 9th SCL high phase (level while count==9)
ack_done  in  1  timer: falling SCL edge ending ACK slot, pulse
sda_in  in  1  synchronized SDA, used to sample master ACK
rx_data  in  8  parallel output of RX shift register, bit0 = R/W
tx_fifo_empty  in  1  TX FIFO has no data
rx_enable  out  1  RX shift register enable
tx_enable  out  1  TX shift register shift enable
load_data  out  1  load TX shift register from FIFO head, 1-cycle pulse
read_enable  out  1  pop TX FIFO, 1-cycle pulse
sda_mode  out  2  00 release/idle-high, 01 drive ACK (low), 10 drive NACK (high), 11 drive TX data

Behaviour:
- Moore FSM. All outputs decode from the registered state, so each output changes the cycle after the input that caused the transition.
- On rst, at any cycle including mid-transfer: state=IDLE, rx_enable=0, tx_enable=0, load_data=0, read_enable=0, sda_mode=00.
- IDLE: all outputs inactive. start_found -> ADDR.
- ADDR: rx_enable=1. byte_received -> ADDR_CHECK.
- ADDR_CHECK: 1 cycle, outputs inactive.
  - Match = rx_data[7:1]==SLAVE_ADDR && rx_data[0]==1 && !tx_fifo_empty.
  - Match -> ACK_WAIT; otherwise -> NACK_WAIT.
- ACK_WAIT: ack_prep -> ACK.
- ACK: sda_mode=01. ack_done -> LOAD.
- NACK_WAIT: ack_prep -> NACK.
- NACK: sda_mode=10. ack_done -> IDLE. The slave is then deaf until the next start_found.
- LOAD: load_data=1 for 1 cycle -> TX.
- TX: sda_mode=11, tx_enable=1. ack_prep -> MACK_WAIT.
- MACK_WAIT: sda_mode=00 (release SDA for master).
  - The first cycle check_ack==1 -> MACK_CHECK.
  - If ack_done arrives without check_ack, treat it as NACK -> IDLE.
- MACK_CHECK: 1 cycle. The registered sda_in sampled on entry is the master ACK.
  - sda_in==0 (ACK) -> POP.
  - sda_in==1 (NACK) -> IDLE.
- POP: read_enable=1 for 1 cycle -> POP_WAIT.
- POP_WAIT: sda_mode=00. ack_done -> LOAD if !tx_fifo_empty, else -> IDLE.
- Global overrides, evaluated before per-state transitions, from any state:
  - stop_found -> IDLE.
  - Else start_found -> ADDR (repeated start).
  - If stop_found and start_found arrive in the same cycle, stop wins.
- read_enable never asserts twice per byte. load_data never asserts while tx_fifo_empty==1.
- Unused state encodings -> IDLE.

Decomposition:
- Shared package i2c_pkg holds:
  - state_t enum (IDLE, ADDR, ADDR_CHECK, ACK_WAIT, ACK, NACK_WAIT, NACK, LOAD, TX, MACK_WAIT, MACK_CHECK, POP, POP_WAIT);
  - sda_mode constants SDA_IDLE=2'b00, SDA_ACK=2'b01, SDA_NACK=2'b10, SDA_TX=2'b11;
  - default SLAVE_ADDR.
- Single module with no sub-module: next-state and output decode are two processes on one state register.

Test Plan:
1. Reset: hold rst=1 for 2 cycles mid-TX -> next cycle state=IDLE, sda_mode=00, all enables 0.
2. Address match: start, rx_data=8'hF1, fifo nonempty, byte_received -> ACK_WAIT, then ack_prep -> sda_mode=01 one cycle later; ack_done -> load_data pulse, then sda_mode=11, tx_enable=1.
3. Address mismatch: rx_data=8'hA1 (or 8'hF0 write, or tx_fifo_empty=1) -> sda_mode=10 during ACK slot, IDLE after ack_done; a further byte_received produces no response.
4. Multi-byte read: 3 bytes, master ACK (sda_in=0 at check_ack) on the first 2 and NACK on the 3rd -> exactly 2 read_enable pulses and 3 load_data pulses, IDLE after the 3rd check.
5. Stop/start overrides: stop_found during TX -> IDLE next cycle, sda_mode=00. start_found during POP_WAIT -> ADDR with rx_enable=1. Both in the same cycle -> IDLE.
